ibex_mac_seq: RTL

//  Parametrised, pipelined multiply/accumulate unit for the vector/filter datapath. Accepts one

---
 rtl/ibex_mac_seq_if.sv | 34 +++
 rtl/ibex_mac_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ibex_mac_seq_if.sv
// Operand/result bus of the pipelined MAC unit. The slave side is the unit;
// the master side is the operand fetch / result writeback logic.
interface ibex_mac_seq_if #(
  parameter int DataWidth = 8,
  parameter int AccWidth  = 24,
  parameter int MaxTaps   = 9
);
  localparam int CntW = $clog2(MaxTaps + 1);

  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [DataWidth-1:0] operand_a_i;
  logic [DataWidth-1:0] operand_b_i;
  logic [1:0]           op_i;
  logic                 signed_i;
  logic                 last_i;
  logic                 clear_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [AccWidth-1:0]  result_o;
  logic                 overflow_o;
  logic                 busy_o;
  logic [CntW-1:0]      tap_count_o;

  modport master (
    output in_valid_i, operand_a_i, operand_b_i, op_i, signed_i, last_i, clear_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, overflow_o, busy_o, tap_count_o
  );

  modport slave (
    input  in_valid_i, operand_a_i, operand_b_i, op_i, signed_i, last_i, clear_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, overflow_o, busy_o, tap_count_o
  );
endinterface

// File: rtl/ibex_mac_seq.sv
// Two-stage ADD/SUB/MULT/MAC unit. Stage 1 forms the exact operand result
// (sum, difference or product) at 2*DataWidth+2 bits; stage 2 either emits it
// or folds it into the accumulator. Sequence bookkeeping (state, tap count,
// first/last flags) is decided at acceptance and travels with the beat.
module ibex_mac_seq #(
  parameter int DataWidth = 8,
  parameter int AccWidth  = 24,
  parameter int MaxTaps   = 9
) (
  input logic          clk_i,
  input logic          rst_i,
  ibex_mac_seq_if.slave bus
);
  localparam int PW   = 2 * DataWidth + 2;
  localparam int CntW = $clog2(MaxTaps + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MAC = 2'b11;

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     tap_q, tap_d;
  logic                s1_valid_q, s1_valid_d, s1_signed_q, s1_signed_d;
  logic                s1_last_q, s1_last_d, s1_first_q, s1_first_d;
  logic [1:0]          s1_op_q, s1_op_d;
  logic [PW-1:0]       s1_val_q, s1_val_d;
  logic [AccWidth-1:0] acc_q, acc_d, result_q, result_d;
  logic                acc_ovf_q, acc_ovf_d, out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;

  logic                adv, in_ready, accept, mac_beat, eff_last;
  logic signed [PW-1:0] a_w, b_w;
  logic [AccWidth-1:0] prod_x, base;
  logic [AccWidth:0]   sum_c;
  logic                base_ovf, step_ovf, s1_mac;

  // Handshake: the whole pipe moves when the output register is free or drained.
  // A beat is forced last when it would bring the tap count to MaxTaps.
  always_comb begin
    adv      = ~out_valid_q | bus.out_ready_i;
    in_ready = ~rst_i & adv & ~bus.clear_i;
    accept   = bus.in_valid_i & in_ready;
    mac_beat = accept & (bus.op_i == OP_MAC);
    eff_last = bus.last_i | (tap_q == CntW'(MaxTaps - 1));
  end

  // FSM next state and tap counter; clear dominates any beat.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    if (bus.clear_i) begin
      state_d = IDLE;
      tap_d   = '0;
    end else if (mac_beat) begin
      if (eff_last) begin
        state_d = IDLE;
        tap_d   = '0;
      end else begin
        state_d = ACCUM;
        tap_d   = tap_q + CntW'(1);
      end
    end
  end

  // FSM / datapath outputs.
  always_comb begin
    bus.in_ready_o  = in_ready;
    bus.busy_o      = (state_q == ACCUM);
    bus.tap_count_o = tap_q;
    bus.out_valid_o = out_valid_q;
    bus.result_o    = result_q;
    bus.overflow_o  = out_ovf_q;
  end

  // Stage 1: extend operands per signed_i and form the exact ADD/SUB/MULT value.
  // A clear kills a MAC beat sitting here even while the pipe is stalled.
  always_comb begin
    a_w = {{(PW - DataWidth){bus.signed_i & bus.operand_a_i[DataWidth-1]}}, bus.operand_a_i};
    b_w = {{(PW - DataWidth){bus.signed_i & bus.operand_b_i[DataWidth-1]}}, bus.operand_b_i};
    s1_valid_d  = s1_valid_q & ~(bus.clear_i & (s1_op_q == OP_MAC));
    s1_op_d     = s1_op_q;
    s1_signed_d = s1_signed_q;
    s1_last_d   = s1_last_q;
    s1_first_d  = s1_first_q;
    s1_val_d    = s1_val_q;
    if (adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_op_d     = bus.op_i;
        s1_signed_d = bus.signed_i;
        s1_last_d   = eff_last;
        s1_first_d  = (state_q == IDLE);
        case (bus.op_i)
          OP_ADD:  s1_val_d = a_w + b_w;
          OP_SUB:  s1_val_d = a_w - b_w;
          default: s1_val_d = a_w * b_w;
        endcase
      end
    end
  end

  // Stage 2: emit plain results, or accumulate and emit on the sequence's last beat.
  // Overflow follows each beat's own signedness and is sticky for the sequence.
  always_comb begin
    if (s1_signed_q) prod_x = AccWidth'(signed'(s1_val_q));
    else             prod_x = AccWidth'(s1_val_q);
    base     = s1_first_q ? '0 : acc_q;
    base_ovf = s1_first_q ? 1'b0 : acc_ovf_q;
    sum_c    = {1'b0, base} + {1'b0, prod_x};
    step_ovf = s1_signed_q ? ((base[AccWidth-1] == prod_x[AccWidth-1]) &
                              (sum_c[AccWidth-1] != base[AccWidth-1]))
                           : sum_c[AccWidth];
    s1_mac   = s1_valid_q & (s1_op_q == OP_MAC) & ~bus.clear_i;

    acc_d       = acc_q;
    acc_ovf_d   = acc_ovf_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    out_ovf_d   = out_ovf_q;
    if (bus.clear_i) begin
      acc_d     = '0;
      acc_ovf_d = 1'b0;
    end
    if (adv) begin
      out_valid_d = 1'b0;
      if (s1_valid_q && (s1_op_q != OP_MAC)) begin
        result_d    = prod_x;
        out_ovf_d   = 1'b0;
        out_valid_d = 1'b1;
      end else if (s1_mac) begin
        if (s1_last_q) begin
          result_d    = sum_c[AccWidth-1:0];
          out_ovf_d   = base_ovf | step_ovf;
          out_valid_d = 1'b1;
          acc_d       = '0;
          acc_ovf_d   = 1'b0;
        end else begin
          acc_d     = sum_c[AccWidth-1:0];
          acc_ovf_d = base_ovf | step_ovf;
        end
      end
    end
  end

  // State register for FSM, both pipeline stages and the accumulator.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_op_q     <= 2'b00;
      s1_signed_q <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_val_q    <= '0;
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_signed_q <= s1_signed_d;
      s1_last_q   <= s1_last_d;
      s1_first_q  <= s1_first_d;
      s1_val_q    <= s1_val_d;
      acc_q       <= acc_d;
      acc_ovf_q   <= acc_ovf_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
    end
  end
endmodule
